// File: rtl/spi_ctrl_pkg.sv
// Shared types and header-field constants for the SPI configuration frame controller.
package spi_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    WR   = 2'd2,
    SKIP = 2'd3
  } state_t;

  localparam int HDR_WR_BIT   = 7;
  localparam int HDR_ADDR_MSB = 6;

  // True when the header's address field names an existing register.
  function automatic logic hdr_addr_ok(input logic [7:0] hdr, input int nreg);
    return int'(hdr[HDR_ADDR_MSB:0]) < nreg;
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for one asynchronous input with registered-previous edge detect.
module spi_sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_p0;
  logic                   prev_p1;

  // Chain and prev share RST_VAL so a level already present at reset release
  // settles without producing a spurious edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_p0 <= {SYNC_STAGES{RST_VAL}};
      prev_p1 <= RST_VAL;
    end else begin
      sync_p0 <= {sync_p0[SYNC_STAGES-2:0], d};
      prev_p1 <= sync_p0[SYNC_STAGES-1];
    end
  end

  assign q    = sync_p0[SYNC_STAGES-1];
  assign rise = q & ~prev_p1;
  assign fall = ~q & prev_p1;

endmodule

// File: rtl/spi_frame_ctrl.sv
// SPI frame controller: header byte selects a start register, data bytes fill consecutive registers.
module spi_frame_ctrl
  import spi_ctrl_pkg::*;
#(
  parameter int NREG        = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    sck,
  input  logic                    sdi,
  input  logic                    cs,
  output logic [NREG*8-1:0]       reg_q,
  output logic                    wr_pulse,
  output logic [$clog2(NREG)-1:0] wr_addr,
  output logic                    frame_err,
  output logic                    busy
);

  localparam int AW = $clog2(NREG);

  logic sck_s, sck_rise, sck_fall;
  logic sdi_s, sdi_rise, sdi_fall;
  logic cs_s, cs_rise, cs_fall;
  logic unused_sync;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sck (
    .clk(clk), .reset(reset), .d(sck), .q(sck_s), .rise(sck_rise), .fall(sck_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sdi (
    .clk(clk), .reset(reset), .d(sdi), .q(sdi_s), .rise(sdi_rise), .fall(sdi_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .clk(clk), .reset(reset), .d(cs), .q(cs_s), .rise(cs_rise), .fall(cs_fall)
  );

  assign unused_sync = ^{sck_s, sck_fall, sdi_rise, sdi_fall};

  // Stage p0: bit sampling on synchronized sck rise while cs is active
  logic       bit_edge;
  logic [6:0] shreg_p0;
  logic [2:0] bitcnt_p0;
  logic [7:0] rx_byte;
  logic       byte_done;

  assign bit_edge  = sck_rise & cs_s;
  assign rx_byte   = {shreg_p0, sdi_s};
  assign byte_done = bit_edge && (bitcnt_p0 == 3'd7);

  always_ff @(posedge clk) begin
    if (bit_edge) begin
      shreg_p0 <= rx_byte[6:0];
    end
  end

  // Stage p1: frame FSM, address counter and register file
  state_t          state_p1;
  logic [AW-1:0]   addr_p1;
  logic [7:0]      regs_p1 [NREG];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_p1  <= IDLE;
      bitcnt_p0 <= 3'd0;
      addr_p1   <= '0;
      wr_pulse  <= 1'b0;
      wr_addr   <= '0;
      frame_err <= 1'b0;
      for (int i = 0; i < NREG; i++) begin
        regs_p1[i] <= 8'h00;
      end
    end else begin
      wr_pulse  <= 1'b0;
      frame_err <= 1'b0;
      if (cs_fall) begin
        state_p1 <= IDLE;
        if (bitcnt_p0 != 3'd0) begin
          frame_err <= 1'b1;
        end
      end else if (cs_rise) begin
        bitcnt_p0 <= 3'd0;
        state_p1  <= HDR;
      end else if (bit_edge) begin
        bitcnt_p0 <= bitcnt_p0 + 3'd1;
        if (byte_done) begin
          case (state_p1)
            HDR: begin
              if (rx_byte[HDR_WR_BIT] && hdr_addr_ok(rx_byte, NREG)) begin
                addr_p1  <= rx_byte[AW-1:0];
                state_p1 <= WR;
              end else begin
                frame_err <= rx_byte[HDR_WR_BIT];
                state_p1  <= SKIP;
              end
            end
            WR: begin
              regs_p1[addr_p1] <= rx_byte;
              wr_pulse         <= 1'b1;
              wr_addr          <= addr_p1;
              addr_p1          <= (addr_p1 == AW'(NREG - 1)) ? '0 : addr_p1 + AW'(1);
            end
            default: ;
          endcase
        end
      end
    end
  end

  for (genvar g = 0; g < NREG; g++) begin : g_reg_q
    assign reg_q[8*g +: 8] = regs_p1[g];
  end

  assign busy = (state_p1 != IDLE);

endmodule
